// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_resp_pkg
//  Description : Shared types and constants for the multi-cycle memory
//                responder: FSM state encoding, word geometry and the
//                depth-to-index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Storage word width and number of byte-offset bits inside a word
    localparam int WORD_BITS  = 32;
    localparam int BYTE_OFF_W = 2;

    // Number of word-index bits needed to address DEPTH words
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_word_array
//  Description : DEPTH x 32-bit word storage with a synchronous write port
//                and a registered, enable-gated read port. The read register
//                holds its value between enabled reads and clears on reset;
//                the storage itself is never cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [IDX_W-1:0]     addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [WORD_BITS-1:0] rdata_q;
    logic [WORD_BITS-1:0] rdata_d;

    // Commit a write into the array on the access edge
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only updates on an enabled read, otherwise holds
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem[addr];
        end
    end

    // Read data register, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/multicycle_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_mem_responder
//  Description : Memory-side responder for the multi-cycle core. Accepts a
//                held read/write request in IDLE, waits a programmable
//                latency, performs the access on the last wait edge and
//                pulses rsp_ready for one cycle in RESP. Misaligned accesses
//                still take the full latency but only raise rsp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W  = idx_width(DEPTH);
    localparam int ADDR_W = IDX_W + BYTE_OFF_W;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    // BUSY lasts LATENCY-1 cycles, counting down to zero inclusive
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WORD_BITS-1:0] wdata_q, wdata_d;
    logic                 is_write_q, is_write_d;
    logic                 err_q, err_d;

    // Access selected for this edge: latched request, or the live request
    // when a single-cycle latency performs the access straight out of IDLE
    logic                 acc_go;
    logic [ADDR_W-1:0]    acc_addr;
    logic [WORD_BITS-1:0] acc_wdata;
    logic                 acc_write;
    logic                 acc_misaligned;
    logic                 arr_wr_en;
    logic                 arr_rd_en;

    // Address bits above the wrapped word range are intentionally ignored
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, req_addr[31:ADDR_W]};

    // Next-state, latch and access-strobe decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        acc_go     = 1'b0;
        acc_addr   = addr_q;
        acc_wdata  = wdata_q;
        acc_write  = is_write_q;

        case (state_q)
            ST_IDLE: begin
                if (req_read | req_write) begin
                    addr_d     = req_addr[ADDR_W-1:0];
                    wdata_d    = req_wdata;
                    // read wins over a simultaneous write
                    is_write_d = ~req_read;
                    if (LATENCY == 1) begin
                        state_d   = ST_RESP;
                        acc_go    = 1'b1;
                        acc_addr  = req_addr[ADDR_W-1:0];
                        acc_wdata = req_wdata;
                        acc_write = ~req_read;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    acc_go  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        acc_misaligned = (acc_addr[BYTE_OFF_W-1:0] != '0);
        err_d          = acc_go & acc_misaligned;
        // reset abandons an access whose commit edge coincides with it
        arr_wr_en      = acc_go &  acc_write & ~acc_misaligned & ~reset;
        arr_rd_en      = acc_go & ~acc_write & ~acc_misaligned & ~reset;
    end

    // State, counter, request latches and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
        end
    end

    mem_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .wr_en (arr_wr_en),
        .rd_en (arr_rd_en),
        .addr  (acc_addr[ADDR_W-1:BYTE_OFF_W]),
        .wdata (acc_wdata),
        .rdata (rsp_rdata)
    );

    assign rsp_ready = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_err   = err_q;

endmodule
`default_nettype wire
